// File: rtl/md_pkg.sv
// Shared MD timestep definitions: fixed-point widths, per-particle vector
// types and the phase-3 sweep state encoding.
package md_pkg;

  localparam int POS_W    = 32;
  localparam int VEL_W    = 32;
  localparam int DT_SHIFT = 8;

  typedef struct packed {
    logic [POS_W-1:0] z;
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } vec3_pos_t;

  typedef struct packed {
    logic signed [VEL_W-1:0] z;
    logic signed [VEL_W-1:0] y;
    logic signed [VEL_W-1:0] x;
  } vec3_vel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE,
    ST_WAIT_LOW
  } p3_state_e;

endpackage

// File: rtl/position_integrator.sv
// One registered compute stage: pos + (vel >>> DT_SHIFT) per axis, with the
// periodic boundary given by plain modulo-2^POS_W wrap.
module position_integrator #(
  parameter int POS_W    = md_pkg::POS_W,
  parameter int VEL_W    = md_pkg::VEL_W,
  parameter int DT_SHIFT = md_pkg::DT_SHIFT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               occupied_i,
  input  logic [3*POS_W-1:0] pos_i,
  input  logic [3*VEL_W-1:0] vel_i,
  output logic [3*POS_W-1:0] pos_o,
  output logic               occupied_o
);

  logic [3*POS_W-1:0] pos_d;
  logic [3*POS_W-1:0] pos_q;
  logic               occupied_q;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    logic signed [VEL_W-1:0] vel_s;
    logic signed [VEL_W-1:0] step_s;
    logic        [POS_W-1:0] delta;

    assign vel_s  = vel_i[a*VEL_W +: VEL_W];
    assign step_s = vel_s >>> DT_SHIFT;
    // Signed cast sign-extends (or truncates) the step to position width.
    assign delta  = POS_W'(step_s);
    assign pos_d[a*POS_W +: POS_W] = occupied_i ? pos_i[a*POS_W +: POS_W] + delta
                                                : pos_i[a*POS_W +: POS_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q      <= '0;
      occupied_q <= 1'b0;
    end else if (en_i) begin
      pos_q      <= pos_d;
      occupied_q <= occupied_i;
    end
  end

  assign pos_o      = pos_q;
  assign occupied_o = occupied_q;

endmodule

// File: rtl/phase3_position_update.sv
// Phase-3 sweep engine: streams every slot of the current bank through the
// integrator into the opposite bank, then pulses phase3_done once.
module phase3_position_update #(
  parameter int N_CELLS        = 64,
  parameter int SLOTS_PER_CELL = 16,
  parameter int ADDR_W         = $clog2(N_CELLS*SLOTS_PER_CELL),
  parameter int POS_W          = md_pkg::POS_W,
  parameter int VEL_W          = md_pkg::VEL_W,
  parameter int DT_SHIFT       = md_pkg::DT_SHIFT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               phase3_ready,
  input  logic               double_buffer,
  output logic               phase3_done,
  output logic               busy,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_bank,
  input  logic [3*POS_W-1:0] rd_pos,
  input  logic [3*VEL_W-1:0] rd_vel,
  input  logic               rd_occupied,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               wr_bank,
  output logic [3*POS_W-1:0] wr_pos,
  output logic               wr_occupied
);

  import md_pkg::*;

  localparam int                N         = N_CELLS * SLOTS_PER_CELL;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  p3_state_e         state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_bank_q;
  logic              wr_bank_q;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              done_q;
  logic              busy_q;

  position_integrator #(
    .POS_W    (POS_W),
    .VEL_W    (VEL_W),
    .DT_SHIFT (DT_SHIFT)
  ) u_integrator (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (s1_valid_q),
    .occupied_i (rd_occupied),
    .pos_i      (rd_pos),
    .vel_i      (rd_vel),
    .pos_o      (wr_pos),
    .occupied_o (wr_occupied)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: defaults first; a later non-blocking assignment in the case
      // below overrides them, which is how an abort squashes the pipeline.
      s1_valid_q <= rd_en_q;
      s1_addr_q  <= rd_addr_q;
      wr_en_q    <= s1_valid_q;
      wr_addr_q  <= s1_addr_q;
      done_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (phase3_ready) begin
            state_q   <= ST_SWEEP;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            rd_bank_q <= double_buffer;
            wr_bank_q <= ~double_buffer;
            busy_q    <= 1'b1;
          end
        end

        ST_SWEEP, ST_DRAIN: begin
          if (!phase3_ready) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
          end else if (state_q == ST_SWEEP) begin
            if (rd_addr_q == LAST_ADDR) begin
              rd_en_q <= 1'b0;
              state_q <= ST_DRAIN;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end else if (!s1_valid_q) begin
            // Only the final write remains in flight; it retires this cycle.
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_WAIT_LOW;
        end

        ST_WAIT_LOW: begin
          if (!phase3_ready) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign phase3_done = done_q;
  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign rd_bank     = rd_bank_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_bank     = wr_bank_q;

endmodule

// File: tb/tb_phase3_position_update.sv
// Directed bench for phase3_position_update with a 4-slot, two-bank memory
// model that answers reads one cycle after rd_en.
module tb_phase3_position_update;

  import md_pkg::*;

  localparam int N  = 4;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           phase3_ready = 1'b0;
  logic           double_buffer = 1'b0;
  logic           phase3_done;
  logic           busy;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           rd_bank;
  logic [95:0]    rd_pos;
  logic [95:0]    rd_vel;
  logic           rd_occupied;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic           wr_bank;
  logic [95:0]    wr_pos;
  logic           wr_occupied;

  int vectors = 0;
  int miscompares = 0;

  logic [95:0] src_pos [2][N];
  logic [95:0] src_vel [2][N];
  logic        src_occ [2][N];
  logic [95:0] exp_pos [N];
  logic        exp_occ [N];

  phase3_position_update #(
    .N_CELLS        (1),
    .SLOTS_PER_CELL (4),
    .ADDR_W         (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .phase3_ready  (phase3_ready),
    .double_buffer (double_buffer),
    .phase3_done   (phase3_done),
    .busy          (busy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_bank       (rd_bank),
    .rd_pos        (rd_pos),
    .rd_vel        (rd_vel),
    .rd_occupied   (rd_occupied),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_bank       (wr_bank),
    .wr_pos        (wr_pos),
    .wr_occupied   (wr_occupied)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_pos      <= src_pos[rd_bank][rd_addr];
      rd_vel      <= src_vel[rd_bank][rd_addr];
      rd_occupied <= src_occ[rd_bank][rd_addr];
    end
  end

  function automatic logic [95:0] pv(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    vec3_pos_t p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  function automatic logic [95:0] vv(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    vec3_vel_t v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  task automatic fill_banks(input logic [31:0] seed);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        src_pos[b][k] = pv(seed + 32'(b*16 + k), 32'h1111, 32'h2222);
        src_vel[b][k] = vv(32'h4000, 32'h0, 32'h0);
        src_occ[b][k] = 1'b1;
      end
    end
  endtask

  // Full sweep from IDLE: cycle c=0 is the first SWEEP cycle S.
  task automatic run_sweep(input logic db);
    logic e_rd, e_wr, e_done;
    @(posedge clk); #1;
    double_buffer = db;
    phase3_ready  = 1'b1;
    for (int c = 0; c < N + 8; c++) begin
      @(posedge clk); #1;
      e_rd   = (c < N);
      e_wr   = (c >= 2) && (c < N + 2);
      e_done = (c == N + 2);
      vectors++;
      if (rd_en !== e_rd) begin
        miscompares++;
        $display("FAIL rd_en c=%0d: got %b want %b", c, rd_en, e_rd);
      end
      vectors++;
      if (wr_en !== e_wr) begin
        miscompares++;
        $display("FAIL wr_en c=%0d: got %b want %b", c, wr_en, e_wr);
      end
      vectors++;
      if (phase3_done !== e_done) begin
        miscompares++;
        $display("FAIL phase3_done c=%0d: got %b want %b", c, phase3_done, e_done);
      end
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy c=%0d: got %b want 1", c, busy);
      end
      if (e_rd) begin
        vectors++;
        if (rd_addr !== AW'(c) || rd_bank !== db) begin
          miscompares++;
          $display("FAIL read c=%0d: got addr %0d bank %b want addr %0d bank %b",
                   c, rd_addr, rd_bank, c, db);
        end
      end
      if (e_wr) begin
        vectors++;
        if (wr_addr !== AW'(c - 2) || wr_bank !== ~db) begin
          miscompares++;
          $display("FAIL write addr c=%0d: got addr %0d bank %b want addr %0d bank %b",
                   c, wr_addr, wr_bank, c - 2, ~db);
        end
        vectors++;
        if (wr_pos !== exp_pos[c-2] || wr_occupied !== exp_occ[c-2]) begin
          miscompares++;
          $display("FAIL wr_pos slot %0d: got %h occ %b want %h occ %b",
                   c - 2, wr_pos, wr_occupied, exp_pos[c-2], exp_occ[c-2]);
        end
      end
    end
    phase3_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy after release: got %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({phase3_done, busy, rd_en, wr_en, wr_occupied} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset strobes: got %b want 00000",
               {phase3_done, busy, rd_en, wr_en, wr_occupied});
    end
    vectors++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_pos !== '0) begin
      miscompares++;
      $display("FAIL reset data: got rd_addr %0d wr_addr %0d wr_pos %h want 0",
               rd_addr, wr_addr, wr_pos);
    end
    vectors++;
    if (rd_bank !== 1'b0 || wr_bank !== 1'b1) begin
      miscompares++;
      $display("FAIL reset banks: got rd %b wr %b want rd 0 wr 1", rd_bank, wr_bank);
    end
    #8 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_banks(32'h9000);
    src_pos[0][0] = pv(100, 0, 0);  src_vel[0][0] = vv(512, 0, 0);
    src_pos[0][1] = pv(1000, 5, 0); src_vel[0][1] = vv(-768, 256, 0);
    src_pos[0][2] = pv(0, 50, 0);   src_vel[0][2] = vv(0, 255, 0);
    src_pos[0][3] = pv(0, 0, 10);   src_vel[0][3] = vv(0, 0, -1);
    exp_pos[0] = pv(102, 0, 0);  exp_occ[0] = 1'b1;
    exp_pos[1] = pv(997, 6, 0);  exp_occ[1] = 1'b1;
    exp_pos[2] = pv(0, 50, 0);   exp_occ[2] = 1'b1;
    exp_pos[3] = pv(0, 0, 9);    exp_occ[3] = 1'b1;
    run_sweep(1'b0);
  endtask

  task automatic test_wrap_unoccupied();
    fill_banks(32'hA000);
    src_pos[0][0] = pv(32'hFFFF_FFFF, 0, 0); src_vel[0][0] = vv(256, 0, 0);
    src_pos[0][1] = pv(0, 0, 0);             src_vel[0][1] = vv(-256, 0, 0);
    src_pos[0][2] = pv(7, 0, 0);             src_vel[0][2] = vv(1000, 0, 0);
    src_occ[0][2] = 1'b0;
    src_pos[0][3] = pv(0, 32'hFFFF_FF00, 0); src_vel[0][3] = vv(0, 32'h8000_0000, 0);
    exp_pos[0] = pv(0, 0, 0);             exp_occ[0] = 1'b1;
    exp_pos[1] = pv(32'hFFFF_FFFF, 0, 0); exp_occ[1] = 1'b1;
    exp_pos[2] = pv(7, 0, 0);             exp_occ[2] = 1'b0;
    exp_pos[3] = pv(0, 32'hFF7F_FF00, 0); exp_occ[3] = 1'b1;
    run_sweep(1'b0);
  endtask

  task automatic test_bank_swap();
    fill_banks(32'hB000);
    for (int k = 0; k < N; k++) begin
      src_pos[1][k] = pv(32'(10*k), 0, 0);
      src_vel[1][k] = vv(32'(256*k), 0, 0);
      exp_pos[k]    = pv(32'(11*k), 0, 0);
      exp_occ[k]    = 1'b1;
    end
    run_sweep(1'b1);
  endtask

  task automatic test_abort();
    fill_banks(32'hC000);
    @(posedge clk); #1;
    double_buffer = 1'b0;
    phase3_ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (wr_en !== (c == 2) || phase3_done !== 1'b0 || busy !== (c <= 2)) begin
        miscompares++;
        $display("FAIL abort c=%0d: got wr_en %b done %b busy %b want %b 0 %b",
                 c, wr_en, phase3_done, busy, (c == 2), (c <= 2));
      end
      if (c >= 3) begin
        vectors++;
        if (rd_en !== 1'b0) begin
          miscompares++;
          $display("FAIL abort rd_en c=%0d: got %b want 0", c, rd_en);
        end
      end
      if (c == 2) phase3_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_banks(32'hD000);
    @(posedge clk); #1;
    double_buffer = 1'b1;
    phase3_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({phase3_done, busy, rd_en, wr_en, wr_occupied, rd_bank, wr_bank} !== 7'b0000001) begin
      miscompares++;
      $display("FAIL mid reset strobes: got %b want 0000001",
               {phase3_done, busy, rd_en, wr_en, wr_occupied, rd_bank, wr_bank});
    end
    vectors++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_pos !== '0) begin
      miscompares++;
      $display("FAIL mid reset data: got rd_addr %0d wr_addr %0d wr_pos %h want 0",
               rd_addr, wr_addr, wr_pos);
    end
    phase3_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_pos[0][k] = pv(32'(100 + k), 0, 0);
      src_vel[0][k] = vv(-512, 0, 0);
      exp_pos[k]    = pv(32'(98 + k), 0, 0);
      exp_occ[k]    = 1'b1;
    end
    run_sweep(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_unoccupied();
    test_bank_swap();
    test_abort();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
